// File: rtl/aes32_unit_seq.sv
// Multi-cycle AES32 round-byte unit (aes32esi/esmi/dsi/dsmi) with valid/ready handshakes.
// S-boxes are computed as GF(2^8) inversion (poly 0x11b) wrapped in the AES affine maps.

package aes32_unit_seq_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] acc;
    p   = a;
    acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (p & {8{b[i]}});
      p   = xtime(p);
    end
    return acc;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < n; i++) begin
      y = {y[6:0], y[7]};
    end
    return y;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] x);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
  endfunction

  // MixColumn byte column, rotation by byte select, and XOR with rs1.
  function automatic logic [31:0] round_word(input logic [7:0] so, input logic dec,
                                             input logic mix, input logic [1:0] bs,
                                             input logic [31:0] rs1);
    logic [31:0] w;
    logic [31:0] r;
    if (!mix) begin
      w = {24'h000000, so};
    end else if (dec) begin
      w = {gf_mul(so, 8'h0b), gf_mul(so, 8'h0d), gf_mul(so, 8'h09), gf_mul(so, 8'h0e)};
    end else begin
      w = {xtime(so) ^ so, so, so, xtime(so)};
    end
    case (bs)
      2'd0:    r = w;
      2'd1:    r = {w[23:0], w[31:24]};
      2'd2:    r = {w[15:0], w[31:16]};
      2'd3:    r = {w[7:0], w[31:8]};
      default: r = w;
    endcase
    return r ^ rs1;
  endfunction

endpackage

module riscv_crypto_aes_fwd_sbox (
  input  logic [7:0] in,
  output logic [7:0] fx
);
  import aes32_unit_seq_pkg::*;
  assign fx = fwd_affine(gf_inv(in));
endmodule

module riscv_crypto_aes_inv_sbox (
  input  logic [7:0] in,
  output logic [7:0] fx
);
  import aes32_unit_seq_pkg::*;
  assign fx = gf_inv(inv_affine(in));
endmodule

module aes32_unit_seq #(
  parameter int LOGIC_GATING = 1,
  parameter int REG_SBOX     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        dec_i,
  input  logic        mix_i,
  input  logic [1:0]  bs_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] rd_o
);
  import aes32_unit_seq_pkg::*;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUB  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  logic [1:0]  state_r;
  logic        dec_r;
  logic        mix_r;
  logic [1:0]  bs_r;
  logic [31:0] rs1_r;
  logic [7:0]  so_r;
  logic [31:0] rd_r;

  logic [7:0]  sel_s;
  logic [7:0]  fwd_s;
  logic [7:0]  inv_s;
  logic [7:0]  so_s;
  logic [31:0] res_s;
  logic        load_s;

  riscv_crypto_aes_fwd_sbox u_fwd_sbox (.in(sel_s), .fx(fwd_s));
  riscv_crypto_aes_inv_sbox u_inv_sbox (.in(sel_s), .fx(inv_s));

  // Byte select, S-box choice and final stage; the final stage reads the captured
  // operands when the S-box is registered, otherwise the live request.
  always_comb begin
    case (bs_i)
      2'd0:    sel_s = rs2_i[7:0];
      2'd1:    sel_s = rs2_i[15:8];
      2'd2:    sel_s = rs2_i[23:16];
      2'd3:    sel_s = rs2_i[31:24];
      default: sel_s = rs2_i[7:0];
    endcase
    so_s = dec_i ? inv_s : fwd_s;
    if (REG_SBOX != 0) begin
      res_s = round_word(so_r, dec_r, mix_r, bs_r, rs1_r);
    end else begin
      res_s = round_word(so_s, dec_i, mix_i, bs_i, rs1_i);
    end
    load_s = (state_r == ST_IDLE) && (valid_i || (LOGIC_GATING == 0));
  end

  // Handshake FSM, operand capture and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      dec_r   <= 1'b0;
      mix_r   <= 1'b0;
      bs_r    <= 2'd0;
      rs1_r   <= 32'h00000000;
      so_r    <= 8'h00;
      rd_r    <= 32'h00000000;
    end else begin
      if (load_s) begin
        dec_r <= dec_i;
        mix_r <= mix_i;
        bs_r  <= bs_i;
        rs1_r <= rs1_i;
        so_r  <= so_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (valid_i) begin
            if (REG_SBOX != 0) begin
              state_r <= ST_SUB;
            end else begin
              state_r <= ST_OUT;
              rd_r    <= res_s;
            end
          end
        end
        ST_SUB: begin
          state_r <= ST_OUT;
          rd_r    <= res_s;
        end
        ST_OUT: begin
          if (ready_i) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign ready_o = (state_r == ST_IDLE);
  assign valid_o = (state_r == ST_OUT);
  assign rd_o    = rd_r;

endmodule

// File: tb/tb_aes32_unit_seq.sv
// Directed bench for aes32_unit_seq (default REG_SBOX=1): hand-computed AES byte results,
// latency, backpressure and reset-abort behaviour.

module tb_aes32_unit_seq;

  logic        clk;
  logic        reset;
  logic        valid_i;
  logic        ready_o;
  logic        dec_i;
  logic        mix_i;
  logic [1:0]  bs_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] rd_o;

  int n_checks = 0;
  int n_errors = 0;

  aes32_unit_seq dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .dec_i(dec_i), .mix_i(mix_i), .bs_i(bs_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .valid_o(valid_o), .ready_i(ready_i), .rd_o(rd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single cycle and waits (bounded) for valid_o.
  task automatic issue(input logic dec, input logic mix, input logic [1:0] bs,
                       input logic [31:0] rs1, input logic [31:0] rs2, input string tag);
    int lat;
    @(negedge clk);
    dec_i = dec; mix_i = mix; bs_i = bs; rs1_i = rs1; rs2_i = rs2;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 32'd2);
  endtask

  // Full op with ready_i high: result, then valid drops and unit is idle again.
  task automatic run_op(input logic dec, input logic mix, input logic [1:0] bs,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] exp, input string tag);
    ready_i = 1'b1;
    issue(dec, mix, bs, rs1, rs2, tag);
    check({tag, "_rd"}, rd_o, exp);
    @(posedge clk); #1;
    check({tag, "_vdrop"}, {31'd0, valid_o}, 32'd0);
    check({tag, "_rdy"}, {31'd0, ready_o}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    dec_i = 1'b0; mix_i = 1'b0; bs_i = 2'd0; rs1_i = 32'h0; rs2_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_rd", rd_o, 32'h00000000);
    @(negedge clk); reset = 1'b0;

    run_op(1'b0, 1'b0, 2'd0, 32'h00000000, 32'h00000000, 32'h00000063, "enc");
    run_op(1'b0, 1'b1, 2'd0, 32'h00000000, 32'h00000000, 32'ha56363c6, "encmix");
    run_op(1'b0, 1'b0, 2'd1, 32'hffffffff, 32'h00005300, 32'hffff12ff, "encrot");
    run_op(1'b1, 1'b0, 2'd0, 32'h00000000, 32'h00000000, 32'h00000052, "dec");
    run_op(1'b1, 1'b1, 2'd0, 32'h00000000, 32'h00000000, 32'h50a7f451, "decmix");
    run_op(1'b1, 1'b1, 2'd0, 32'h00000000, 32'h00000063, 32'h00000000, "decmix63");
    run_op(1'b0, 1'b1, 2'd2, 32'h00000000, 32'h00530000, 32'hedc12ced, "encmixb2");
    run_op(1'b1, 1'b1, 2'd3, 32'h12345678, 32'h7c000000, 32'h1c3f5b71, "decmixb3");

    // Backpressure: result held while ready_i is low, inputs are ignored.
    ready_i = 1'b0;
    issue(1'b0, 1'b1, 2'd0, 32'h00000000, 32'h00000000, "bp");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid_i = ~valid_i; rs1_i = $urandom; rs2_i = $urandom; bs_i = 2'(i);
      @(posedge clk); #1;
      check("bp_rd", rd_o, 32'ha56363c6);
      check("bp_valid", {31'd0, valid_o}, 32'd1);
      check("bp_ready", {31'd0, ready_o}, 32'd0);
    end
    @(negedge clk); ready_i = 1'b1; valid_i = 1'b0;
    @(posedge clk); #1;
    check("bp_rel_valid", {31'd0, valid_o}, 32'd0);
    check("bp_rel_ready", {31'd0, ready_o}, 32'd1);
    @(posedge clk); #1;
    check("bp_noaccept", {31'd0, ready_o}, 32'd1);

    // Reset while in SUB aborts the op.
    @(negedge clk);
    dec_i = 1'b0; mix_i = 1'b1; bs_i = 2'd0; rs1_i = 32'h0; rs2_i = 32'h0; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    check("sub_state", {31'd0, ready_o}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rsub_valid", {31'd0, valid_o}, 32'd0);
    check("rsub_ready", {31'd0, ready_o}, 32'd1);
    check("rsub_rd", rd_o, 32'h00000000);
    @(posedge clk); #1;
    check("rsub_stale", {31'd0, valid_o}, 32'd0);
    run_op(1'b0, 1'b0, 2'd0, 32'h00000000, 32'h00000000, 32'h00000063, "after_rsub");

    // Reset while in OUT drops the pending result.
    ready_i = 1'b0;
    issue(1'b1, 1'b0, 2'd0, 32'h00000000, 32'h00000000, "rout");
    check("rout_pre_rd", rd_o, 32'h00000052);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("rout_valid", {31'd0, valid_o}, 32'd0);
    check("rout_rd", rd_o, 32'h00000000);
    @(negedge clk); reset = 1'b0;
    run_op(1'b0, 1'b0, 2'd0, 32'h00000000, 32'h00000000, 32'h00000063, "after_rout");

    // valid_i together with reset: no accept.
    @(negedge clk); reset = 1'b1; valid_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b0; valid_i = 1'b0;
    @(posedge clk); #1;
    check("rst_wins_ready", {31'd0, ready_o}, 32'd1);
    @(posedge clk); #1;
    check("rst_wins_valid", {31'd0, valid_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
